// File: rtl/aqp_ebus_arbiter_if.sv
// Bundle of signals between the ebus arbiter, its two requesters, the Z80
// BUSREQ/BUSACK pins and the external bus.
//   master : arbiter view (takes requests and BUSACK, drives grants, ebus, BUSREQ)
//   slave  : environment view (requesters, CPU and bus side)
// Signals:
//   mN_busreq_n, mN_a, mN_wrdata, mN_wrdata_en, mN_rd_n/wr_n/mreq_n/iorq_n : requester N
//   mN_grant, mN_rddata                                     : back to requester N
//   ebus_phi, cpu_busack_n, ebus_d_in                       : from Z80 side
//   cpu_busreq_n, ebus_a, ebus_d_out, ebus_d_oe, strobes    : to Z80 side
//   ack_timeout                                             : aborted-request pulse
interface aqp_ebus_arbiter_if;
    logic        m0_busreq_n;
    logic [15:0] m0_a;
    logic [7:0]  m0_wrdata;
    logic        m0_wrdata_en;
    logic        m0_rd_n;
    logic        m0_wr_n;
    logic        m0_mreq_n;
    logic        m0_iorq_n;
    logic        m0_grant;
    logic [7:0]  m0_rddata;

    logic        m1_busreq_n;
    logic [15:0] m1_a;
    logic [7:0]  m1_wrdata;
    logic        m1_wrdata_en;
    logic        m1_rd_n;
    logic        m1_wr_n;
    logic        m1_mreq_n;
    logic        m1_iorq_n;
    logic        m1_grant;
    logic [7:0]  m1_rddata;

    logic        ebus_phi;
    logic        cpu_busreq_n;
    logic        cpu_busack_n;
    logic [15:0] ebus_a;
    logic [7:0]  ebus_d_in;
    logic [7:0]  ebus_d_out;
    logic        ebus_d_oe;
    logic        ebus_rd_n;
    logic        ebus_wr_n;
    logic        ebus_mreq_n;
    logic        ebus_iorq_n;
    logic        ack_timeout;

    modport master (
        input  m0_busreq_n, m0_a, m0_wrdata, m0_wrdata_en, m0_rd_n, m0_wr_n, m0_mreq_n, m0_iorq_n,
        input  m1_busreq_n, m1_a, m1_wrdata, m1_wrdata_en, m1_rd_n, m1_wr_n, m1_mreq_n, m1_iorq_n,
        input  ebus_phi, cpu_busack_n, ebus_d_in,
        output m0_grant, m0_rddata, m1_grant, m1_rddata,
        output cpu_busreq_n, ebus_a, ebus_d_out, ebus_d_oe,
        output ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n, ack_timeout
    );

    modport slave (
        output m0_busreq_n, m0_a, m0_wrdata, m0_wrdata_en, m0_rd_n, m0_wr_n, m0_mreq_n, m0_iorq_n,
        output m1_busreq_n, m1_a, m1_wrdata, m1_wrdata_en, m1_rd_n, m1_wr_n, m1_mreq_n, m1_iorq_n,
        output ebus_phi, cpu_busack_n, ebus_d_in,
        input  m0_grant, m0_rddata, m1_grant, m1_rddata,
        input  cpu_busreq_n, ebus_a, ebus_d_out, ebus_d_oe,
        input  ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n, ack_timeout
    );
endinterface

// File: rtl/aqp_ebus_arbiter.sv
// Shares the external Z80 bus between two requesters (m0 = ESP SPI master,
// m1 = second master). Runs the BUSREQ/BUSACK handshake, grants one requester
// at a time with round-robin fairness and muxes the owner onto the ebus.
// Every ownership change happens on a falling edge of ebus_phi.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : aqp_ebus_arbiter_if.master (requesters, CPU handshake, ebus)
// Parameters:
//   ACK_TIMEOUT : phi cycles to wait for BUSACK before aborting (1..255)
//   SYNC_STAGES : synchroniser depth for cpu_busack_n (2..3)
module aqp_ebus_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    aqp_ebus_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, ACQ, OWN, REL} state_t;

    state_t                 r_state;
    logic                   r_q_phi;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   r_owner;
    logic                   r_rr;
    logic                   r_busreq_n;
    logic                   r_ack_timeout;
    logic [1:0]             r_grant;
    logic [7:0]             r_cnt;

    logic                   w_phi_fall;
    logic                   w_ack_s;
    logic                   w_req0;
    logic                   w_req1;
    logic                   w_owner_req;
    logic [7:0]             w_cnt_nxt;

    assign w_phi_fall  = r_q_phi & ~bus.ebus_phi;
    assign w_ack_s     = r_ack_sync[SYNC_STAGES-1];
    assign w_req0      = ~bus.m0_busreq_n;
    assign w_req1      = ~bus.m1_busreq_n;
    assign w_owner_req = r_owner ? w_req1 : w_req0;
    assign w_cnt_nxt   = r_cnt + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q_phi    <= 1'b0;
            r_ack_sync <= '1;
        end else begin
            r_q_phi    <= bus.ebus_phi;
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.cpu_busack_n};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_rr          <= 1'b1;
            r_busreq_n    <= 1'b1;
            r_ack_timeout <= 1'b0;
            r_grant       <= '0;
            r_cnt         <= '0;
        end else begin
            r_ack_timeout <= 1'b0;
            if (w_phi_fall) begin
                case (r_state)
                    IDLE: begin
                        // Waiting for ack_s high here gives the CPU at least one
                        // free phi cycle between ownerships.
                        if (w_ack_s && (w_req0 || w_req1)) begin
                            r_owner    <= (w_req0 && w_req1) ? ~r_rr : w_req1;
                            r_busreq_n <= 1'b0;
                            r_cnt      <= '0;
                            r_state    <= ACQ;
                        end
                    end
                    ACQ: begin
                        if (!w_ack_s) begin
                            r_grant <= r_owner ? 2'b10 : 2'b01;
                            r_state <= OWN;
                        end else if (!w_owner_req) begin
                            // Release takes priority over a coincident timeout.
                            r_state <= REL;
                        end else if (w_cnt_nxt == 8'(ACK_TIMEOUT)) begin
                            r_ack_timeout <= 1'b1;
                            r_state       <= REL;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                    OWN: begin
                        if (!w_owner_req) begin
                            r_grant <= '0;
                            r_state <= REL;
                        end
                    end
                    REL: begin
                        r_busreq_n <= 1'b1;
                        r_rr       <= r_owner;
                        r_state    <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Owner's bus signals pass straight through while owned; parked otherwise.
    always_comb begin
        bus.ebus_a      = '0;
        bus.ebus_d_out  = '0;
        bus.ebus_d_oe   = 1'b0;
        bus.ebus_rd_n   = 1'b1;
        bus.ebus_wr_n   = 1'b1;
        bus.ebus_mreq_n = 1'b1;
        bus.ebus_iorq_n = 1'b1;
        if (r_state == OWN) begin
            if (r_owner) begin
                bus.ebus_a      = bus.m1_a;
                bus.ebus_d_out  = bus.m1_wrdata;
                bus.ebus_d_oe   = bus.m1_wrdata_en;
                bus.ebus_rd_n   = bus.m1_rd_n;
                bus.ebus_wr_n   = bus.m1_wr_n;
                bus.ebus_mreq_n = bus.m1_mreq_n;
                bus.ebus_iorq_n = bus.m1_iorq_n;
            end else begin
                bus.ebus_a      = bus.m0_a;
                bus.ebus_d_out  = bus.m0_wrdata;
                bus.ebus_d_oe   = bus.m0_wrdata_en;
                bus.ebus_rd_n   = bus.m0_rd_n;
                bus.ebus_wr_n   = bus.m0_wr_n;
                bus.ebus_mreq_n = bus.m0_mreq_n;
                bus.ebus_iorq_n = bus.m0_iorq_n;
            end
        end
    end

    assign bus.m0_grant     = r_grant[0];
    assign bus.m1_grant     = r_grant[1];
    assign bus.m0_rddata    = bus.ebus_d_in;
    assign bus.m1_rddata    = bus.ebus_d_in;
    assign bus.cpu_busreq_n = r_busreq_n;
    assign bus.ack_timeout  = r_ack_timeout;

endmodule

// File: tb/tb_aqp_ebus_arbiter.sv
// Self-checking bench for aqp_ebus_arbiter: a phi-by-phi vector table, hand
// sequences for pass-through, mid-write release, async reset and glitches,
// and randomized traffic against a transaction-level ownership model.
module tb_aqp_ebus_arbiter;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    aqp_ebus_arbiter_if bus();

    aqp_ebus_arbiter #(.ACK_TIMEOUT(TO), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // {r0, r1, busack_n, exp cpu_busreq_n, exp m0_grant, exp m1_grant, exp ack_timeout}
    typedef struct packed {
        logic r0;
        logic r1;
        logic bak_n;
        logic e_brq_n;
        logic e_g0;
        logic e_g1;
        logic e_to;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic s_to, s_to_after, s_pre_wr_n, s_wr_n, s_doe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.m0_busreq_n = 1'b1; bus.m0_a = '0; bus.m0_wrdata = '0; bus.m0_wrdata_en = 1'b0;
        bus.m0_rd_n = 1'b1; bus.m0_wr_n = 1'b1; bus.m0_mreq_n = 1'b1; bus.m0_iorq_n = 1'b1;
        bus.m1_busreq_n = 1'b1; bus.m1_a = '0; bus.m1_wrdata = '0; bus.m1_wrdata_en = 1'b0;
        bus.m1_rd_n = 1'b1; bus.m1_wr_n = 1'b1; bus.m1_mreq_n = 1'b1; bus.m1_iorq_n = 1'b1;
        bus.cpu_busack_n = 1'b1;
        bus.ebus_d_in = '0;
    endtask

    task automatic do_reset(input bit chk);
        reset_n = 1'b0;
        idle_inputs();
        bus.ebus_phi = 1'b0;
        repeat (3) @(negedge clk);
        if (chk) begin
            check("rst_busreq_n", bus.cpu_busreq_n, 1);
            check("rst_grants", {bus.m1_grant, bus.m0_grant}, 0);
            check("rst_strobes", {bus.ebus_rd_n, bus.ebus_wr_n, bus.ebus_mreq_n, bus.ebus_iorq_n}, 4'hF);
            check("rst_d_oe", bus.ebus_d_oe, 0);
            check("rst_ebus_a", bus.ebus_a, 0);
            check("rst_d_out", bus.ebus_d_out, 0);
            check("rst_ack_timeout", bus.ack_timeout, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One full phi period; inputs set by the caller before the call are seen
    // at the falling edge. Returns on a negedge with phi low.
    task automatic phi_cycle();
        bus.ebus_phi = 1'b1;
        repeat (4) @(negedge clk);
        s_pre_wr_n = bus.ebus_wr_n;
        bus.ebus_phi = 1'b0;
        @(posedge clk); #1;
        s_to   = bus.ack_timeout;
        s_wr_n = bus.ebus_wr_n;
        s_doe  = bus.ebus_d_oe;
        @(posedge clk); #1;
        s_to_after = bus.ack_timeout;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        vec_t tbl [33];
        bit   r0, r1, ak;
        int   m_owner, m_last, m_wait;
        bit   m_brq, m_grant, m_rel, m_to;
        bit   req [2];
        logic [15:0] a [2];
        logic [15:0] exp_a;
        logic        mq [2];

        tbl = '{7'b111_0000, 7'b110_0100, 7'b110_0100, 7'b010_0000, 7'b010_1000,
                7'b010_1000, 7'b011_0000, 7'b010_0010, 7'b000_0000, 7'b001_1000,
                7'b101_0000, 7'b101_0000, 7'b101_0000, 7'b101_0000, 7'b101_0001,
                7'b101_1000, 7'b011_0000, 7'b001_0000, 7'b001_1000, 7'b111_0000,
                7'b110_0100, 7'b010_0000, 7'b011_1000, 7'b111_0000, 7'b110_0010,
                7'b100_0000, 7'b101_1000, 7'b101_0000, 7'b101_0000, 7'b101_0000,
                7'b101_0000, 7'b001_0000, 7'b001_1000};

        // ---------------- table-driven phi sequence ----------------
        do_reset(1'b1);
        for (int i = 0; i < 33; i++) begin
            bus.m0_busreq_n  = ~tbl[i].r0;
            bus.m1_busreq_n  = ~tbl[i].r1;
            bus.cpu_busack_n = tbl[i].bak_n;
            phi_cycle();
            check($sformatf("tbl%0d_busreq_n", i), bus.cpu_busreq_n, tbl[i].e_brq_n);
            check($sformatf("tbl%0d_m0_grant", i), bus.m0_grant, tbl[i].e_g0);
            check($sformatf("tbl%0d_m1_grant", i), bus.m1_grant, tbl[i].e_g1);
            check($sformatf("tbl%0d_ack_timeout", i), s_to, tbl[i].e_to);
            check($sformatf("tbl%0d_timeout_1clk", i), s_to_after, 0);
        end

        // ---------------- m0 write, pass-through, mid-write release ----------------
        do_reset(1'b0);
        bus.m0_a = 16'h3000; bus.m0_wrdata = 8'hA5; bus.m0_wrdata_en = 1'b1;
        bus.m0_wr_n = 1'b0; bus.m0_mreq_n = 1'b0; bus.m0_busreq_n = 1'b0;
        phi_cycle();
        check("A_busreq_low", bus.cpu_busreq_n, 0);
        check("A_no_grant_acq", bus.m0_grant, 0);
        check("A_parked_wr_n", bus.ebus_wr_n, 1);
        check("A_parked_a", bus.ebus_a, 0);
        check("A_parked_d_oe", bus.ebus_d_oe, 0);
        phi_cycle();
        phi_cycle();
        check("A_still_waiting", bus.m0_grant, 0);
        bus.cpu_busack_n = 1'b0;
        phi_cycle();
        check("A_m0_grant", bus.m0_grant, 1);
        check("A_m1_no_grant", bus.m1_grant, 0);
        check("A_ebus_a", bus.ebus_a, 16'h3000);
        check("A_d_out", bus.ebus_d_out, 8'hA5);
        check("A_d_oe", bus.ebus_d_oe, 1);
        check("A_wr_n", bus.ebus_wr_n, 0);
        check("A_mreq_n", bus.ebus_mreq_n, 0);
        bus.m0_a = 16'h3001;
        bus.ebus_d_in = 8'h5C;
        #1;
        check("A_same_cycle_a", bus.ebus_a, 16'h3001);
        check("A_rddata0", bus.m0_rddata, 8'h5C);
        check("A_rddata1", bus.m1_rddata, 8'h5C);
        bus.m1_busreq_n = 1'b0;
        phi_cycle();
        check("A_nonowner_ignored_m0", bus.m0_grant, 1);
        check("A_nonowner_ignored_m1", bus.m1_grant, 0);
        bus.m0_busreq_n = 1'b0;
        bus.m0_busreq_n = 1'b1;
        phi_cycle();
        check("A_wr_n_before_drop", s_pre_wr_n, 0);
        check("A_wr_n_after_drop", s_wr_n, 1);
        check("A_d_oe_after_drop", s_doe, 0);
        check("A_grant_dropped", bus.m0_grant, 0);
        check("A_rel_busreq", bus.cpu_busreq_n, 0);
        phi_cycle();
        check("A_idle_busreq", bus.cpu_busreq_n, 1);
        bus.cpu_busack_n = 1'b1;
        bus.m1_rd_n = 1'b0; bus.m1_mreq_n = 1'b0; bus.m1_a = 16'hBEEF;
        phi_cycle();
        check("A_m1_acq", bus.cpu_busreq_n, 0);
        bus.cpu_busack_n = 1'b0;
        phi_cycle();
        check("A_m1_grant", bus.m1_grant, 1);
        check("A_m1_rd_n", bus.ebus_rd_n, 0);
        check("A_m1_a", bus.ebus_a, 16'hBEEF);

        // ---------------- asynchronous reset while owned ----------------
        #1 reset_n = 1'b0;
        #1;
        check("R_grants", {bus.m1_grant, bus.m0_grant}, 0);
        check("R_busreq_n", bus.cpu_busreq_n, 1);
        check("R_strobes", {bus.ebus_rd_n, bus.ebus_wr_n, bus.ebus_mreq_n, bus.ebus_iorq_n}, 4'hF);
        check("R_ebus_a", bus.ebus_a, 0);

        // ---------------- short request glitch between phi falls ----------------
        do_reset(1'b0);
        @(negedge clk) bus.m0_busreq_n = 1'b0;
        @(negedge clk) bus.m0_busreq_n = 1'b1;
        phi_cycle();
        check("G_glitch_ignored", bus.cpu_busreq_n, 1);

        // ---------------- randomized traffic vs ownership model ----------------
        do_reset(1'b0);
        r0 = 0; r1 = 0; ak = 0;
        m_owner = -1; m_last = 1; m_wait = 0;
        m_brq = 0; m_grant = 0; m_rel = 0; m_to = 0;
        for (int it = 0; it < 250; it++) begin
            // CPU acknowledges some time after BUSREQ, frees the bus some time after release
            if (m_brq) begin
                if (!ak && $urandom_range(0, 2) == 0) ak = 1;
            end else if (ak && $urandom_range(0, 1) == 0) begin
                ak = 0;
            end
            if ($urandom_range(0, 3) == 0) r0 = ~r0;
            if ($urandom_range(0, 3) == 0) r1 = ~r1;
            a[0] = 16'($urandom); a[1] = 16'($urandom);
            mq[0] = 1'($urandom); mq[1] = 1'($urandom);
            bus.m0_busreq_n = ~r0; bus.m1_busreq_n = ~r1; bus.cpu_busack_n = ~ak;
            bus.m0_a = a[0]; bus.m1_a = a[1];
            bus.m0_mreq_n = mq[0]; bus.m1_mreq_n = mq[1];
            bus.ebus_d_in = 8'($urandom);
            phi_cycle();

            req[0] = r0; req[1] = r1;
            m_to = 0;
            if (m_rel) begin
                m_brq = 0; m_last = m_owner; m_owner = -1; m_rel = 0;
            end else if (m_owner < 0) begin
                if (!ak && (r0 || r1)) begin
                    m_owner = (r0 && r1) ? 1 - m_last : (r0 ? 0 : 1);
                    m_brq = 1; m_wait = 0;
                end
            end else if (!m_grant) begin
                if (ak) m_grant = 1;
                else if (!req[m_owner]) m_rel = 1;
                else begin
                    m_wait++;
                    if (m_wait >= TO) begin m_to = 1; m_rel = 1; end
                end
            end else if (!req[m_owner]) begin
                m_grant = 0; m_rel = 1;
            end

            exp_a = m_grant ? a[m_owner] : 16'h0000;
            check($sformatf("rnd%0d_busreq_n", it), bus.cpu_busreq_n, !m_brq);
            check($sformatf("rnd%0d_m0_grant", it), bus.m0_grant, m_grant && m_owner == 0);
            check($sformatf("rnd%0d_m1_grant", it), bus.m1_grant, m_grant && m_owner == 1);
            check($sformatf("rnd%0d_ack_timeout", it), s_to, m_to);
            check($sformatf("rnd%0d_ebus_a", it), bus.ebus_a, exp_a);
            check($sformatf("rnd%0d_mreq_n", it), bus.ebus_mreq_n, m_grant ? mq[m_owner] : 1'b1);
            check($sformatf("rnd%0d_rddata", it), bus.m1_rddata, bus.ebus_d_in);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
